// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // At least one counter bit even for the smallest legal width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor d = a - b - bi, LSB first, with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_4bit
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_brw;
    logic [WIDTH-1:0]   r_d;
    logic               r_bo;
    logic               r_done;
`ifdef SERIAL_SUB_OVF_EN
    logic               r_ovf;
`endif

    logic               w_diff;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_brw),
        .diff (w_diff),
        .bout (w_bout)
    );

    assign w_last     = (r_cnt == CNT_LAST);
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // Working shift registers are kept apart from d/bo so outputs stay frozen during RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_brw  <= 1'b0;
            r_d    <= '0;
            r_bo   <= 1'b0;
            r_done <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_brw <= bi;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_brw <= w_bout;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_d    <= w_res_next;
                        r_bo   <= w_bout;
                        r_done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        // Signed overflow: borrow into and out of the MSB differ.
                        r_ovf  <= r_brw ^ w_bout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign d    = r_d;
    assign bo   = r_bo;
    assign busy = (r_state == ST_RUN);
    assign done = r_done;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit (WIDTH=4), optional SERIAL_SUB_OVF_EN.
module tb_serial_subtractor_4bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] d;
    logic       bo;
    logic       busy;
    logic       done;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .d     (d),
        .bo    (bo),
        .busy  (busy),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model_sub(input int av, input int bv, input int biv);
        int r;
        r = av - bv - biv;
        return 5'(r);
    endfunction

    function automatic logic model_ovf(input int av, input int bv, input int biv);
        int sa;
        int sb;
        int r;
        sa = (av >= 8) ? av - 16 : av;
        sb = (bv >= 8) ? bv - 16 : bv;
        r  = sa - sb - biv;
        return (r < -8) || (r > 7);
    endfunction

    // Launch one operation from IDLE and return edges from accept to done (20 = timeout).
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic biv,
                          output int lat);
        @(negedge clk);
        a = av; b = bv; bi = biv; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom); bi = 1'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({d, bo, busy, done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got d=%h bo=%b busy=%b done=%b expected all 0",
                     d, bo, busy, done);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        run_op(4'd5, 4'd3, 1'b0, lat);
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL basic_lat: got %0d expected 4", lat); end
        n_checks++;
        if ({bo, d} !== 5'h02) begin
            n_fail++; $display("FAIL basic_5m3: got bo=%b d=%h expected bo=0 d=2", bo, d);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || d !== 4'h2) begin
            n_fail++; $display("FAIL basic_hold: got done=%b d=%h expected done=0 d=2", done, d);
        end
        run_op(4'd3, 4'd5, 1'b0, lat);
        n_checks++;
        if ({bo, d} !== 5'h1E || lat != 4) begin
            n_fail++; $display("FAIL basic_3m5: got bo=%b d=%h lat=%0d expected bo=1 d=e lat=4",
                               bo, d, lat);
        end
        run_op(4'd0, 4'd0, 1'b1, lat);
        n_checks++;
        if ({bo, d} !== 5'h1F || lat != 4) begin
            n_fail++; $display("FAIL basic_0m0m1: got bo=%b d=%h lat=%0d expected bo=1 d=f lat=4",
                               bo, d, lat);
        end
        run_op(4'd8, 4'd1, 1'b0, lat);
        n_checks++;
        if ({bo, d} !== 5'h07) begin
            n_fail++; $display("FAIL basic_8m1: got bo=%b d=%h expected bo=0 d=7", bo, d);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL basic_ovf: got %b expected 1", ovf); end
`endif
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        a = 4'd9; b = 4'd4; bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %b expected 1", busy); end
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            start = (lat < 2); a = 4'd1; b = 4'd1; bi = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (done) break;
            n_checks++;
            if (d !== 4'h7) begin
                n_fail++; $display("FAIL busy_d_stable: got %h expected 7", d);
            end
        end
        n_checks++;
        if (lat != 4 || {bo, d} !== 5'h05) begin
            n_fail++; $display("FAIL busy_ignore: got bo=%b d=%h lat=%0d expected bo=0 d=5 lat=4",
                               bo, d, lat);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] qa[6];
        logic [3:0] qb[6];
        logic       qbi[6];
        int         lat;
        for (int i = 0; i < 6; i++) begin
            qa[i] = 4'($urandom); qb[i] = 4'($urandom); qbi[i] = 1'($urandom);
        end
        @(negedge clk);
        a = qa[0]; b = qb[0]; bi = qbi[0]; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            lat = 0;
            while (lat < 20) begin
                @(posedge clk); #1;
                lat++;
                if (done) break;
            end
            // First result counts from the accept edge; later ones include the IDLE accept cycle.
            n_checks++;
            if (lat != ((i == 0) ? 4 : 5)) begin
                n_fail++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", i, lat,
                                   (i == 0) ? 4 : 5);
            end
            n_checks++;
            if ({bo, d} !== model_sub(qa[i], qb[i], qbi[i])) begin
                n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, {bo, d},
                                   model_sub(qa[i], qb[i], qbi[i]));
            end
            if (i < 5) begin
                a = qa[i+1]; b = qb[i+1]; bi = qbi[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int lat;
        run_op(4'd12, 4'd3, 1'b0, lat);
        @(negedge clk);
        a = 4'd9; b = 4'd4; bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({d, bo, busy, done} !== 7'b0) begin
            n_fail++; $display("FAIL midrun_reset: got d=%h bo=%b busy=%b done=%b expected all 0",
                               d, bo, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL midrun_no_done: got done=%b busy=%b expected 0 0",
                                   done, busy);
            end
        end
        run_op(4'd6, 4'd2, 1'b1, lat);
        n_checks++;
        if (lat != 4 || {bo, d} !== 5'h03) begin
            n_fail++; $display("FAIL midrun_after: got bo=%b d=%h lat=%0d expected bo=0 d=3 lat=4",
                               bo, d, lat);
        end
    endtask

    task automatic test_exhaustive();
        int lat;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ibi = 0; ibi < 2; ibi++) begin
                    run_op(4'(ia), 4'(ib), 1'(ibi), lat);
                    n_checks++;
                    if (lat != 4) begin
                        n_fail++; $display("FAIL sweep_lat %0d-%0d-%0d: got %0d expected 4",
                                           ia, ib, ibi, lat);
                    end
                    n_checks++;
                    if ({bo, d} !== model_sub(ia, ib, ibi)) begin
                        n_fail++; $display("FAIL sweep_res %0d-%0d-%0d: got %h expected %h",
                                           ia, ib, ibi, {bo, d}, model_sub(ia, ib, ibi));
                    end
`ifdef SERIAL_SUB_OVF_EN
                    n_checks++;
                    if (ovf !== model_ovf(ia, ib, ibi)) begin
                        n_fail++; $display("FAIL sweep_ovf %0d-%0d-%0d: got %b expected %b",
                                           ia, ib, ibi, ovf, model_ovf(ia, ib, ibi));
                    end
`endif
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midrun();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
